// File: rtl/gpu_pkg.sv
// Shared constants for the gpu command front end: register offsets,
// STATUS/CTRL bit positions and the command-word width.
package gpu_pkg;

  localparam int CMD_W = 32;

  localparam logic [3:0] REG_CMD    = 4'd0;
  localparam logic [3:0] REG_STATUS = 4'd1;
  localparam logic [3:0] REG_CTRL   = 4'd2;

  localparam int ST_EMPTY  = 8;
  localparam int ST_FULL   = 9;
  localparam int ST_OVF    = 10;
  localparam int ST_LOW    = 11;
  localparam int ST_IRQ_EN = 12;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_IRQ_EN  = 2;

endpackage

// File: rtl/gpu_fifo_mem.sv
// DEPTH x CMD_W register array: one synchronous write port and one
// combinational read port. Pointer/count bookkeeping lives in the parent.
module gpu_fifo_mem
  import gpu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [CMD_W-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [CMD_W-1:0] o_rd_data
);

  logic [CMD_W-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset; the count/valid logic guarantees stale
  // entries are never presented, so clearing it would only cost flops.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/gpu_cmd_fifo.sv
// Wishbone-slave command FIFO in front of the gpu core: SoC writes command
// words, the gpu drains them over valid/ready, with status, control and IRQ.
module gpu_cmd_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int LOW_WATER = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [3:0]       wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic             cmd_valid_o,
  output logic [CMD_W-1:0] cmd_data_o,
  input  logic             cmd_ready_i,
  output logic             irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] LW_CNT   = CW'(LOW_WATER);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic            r_ack;
  logic [31:0]     r_dat;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic            r_irq_en;
  logic            r_irq;

  logic            w_req;
  logic            w_push_req;
  logic            w_ctrl_wr;
  logic            w_flush;
  logic            w_clr_ovf;
  logic            w_pop;
  logic            w_push;
  logic            w_empty;
  logic            w_full;
  logic            w_low_water;
  logic [31:0]     w_status;
  logic [31:0]     w_rd_data;
  logic            w_unused_sel;

  assign w_req      = wbs_stb_i & wbs_cyc_i & ~r_ack;
  assign w_push_req = w_req & wbs_we_i & (wbs_adr_i == REG_CMD);
  assign w_ctrl_wr  = w_req & wbs_we_i & (wbs_adr_i == REG_CTRL) & wbs_sel_i[0];
  assign w_flush    = w_ctrl_wr & wbs_dat_i[CTRL_FLUSH];
  assign w_clr_ovf  = w_ctrl_wr & wbs_dat_i[CTRL_CLR_OVF];

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == FULL_CNT);
  assign w_low_water = (r_count <= LW_CNT);

  // A flush takes precedence over a handshake on the same edge, so the
  // head entry is never delivered and then re-presented.
  assign w_pop  = ~w_empty & cmd_ready_i & ~w_flush;
  assign w_push = w_push_req & (~w_full | w_pop);

  assign w_status = {19'b0, r_irq_en, w_low_water, r_overflow, w_full, w_empty,
                     8'(r_count)};

  assign w_unused_sel = &{1'b0, wbs_sel_i[3:1]};

  always_comb begin
    w_rd_data = '0;
    if (!wbs_we_i) begin
      case (wbs_adr_i)
        REG_STATUS: w_rd_data = w_status;
        REG_CTRL:   w_rd_data[CTRL_IRQ_EN] = r_irq_en;
        default:    w_rd_data = '0;
      endcase
    end
  end

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples the pre-edge value of the others.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack      <= 1'b0;
      r_dat      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_irq_en   <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_req ? w_rd_data : '0;

      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;

      if (w_flush)    r_rd_ptr <= r_wr_ptr;
      else if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;

      if (w_flush)                r_count <= '0;
      else if (w_push && !w_pop)  r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push)  r_count <= r_count - CNT_ONE;

      // A dropped push and a clear on the same edge leave overflow set.
      if (w_push_req && !w_push) r_overflow <= 1'b1;
      else if (w_clr_ovf)        r_overflow <= 1'b0;

      if (w_ctrl_wr) r_irq_en <= wbs_dat_i[CTRL_IRQ_EN];

      r_irq <= w_low_water & r_irq_en;
    end
  end

  gpu_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk     (wb_clk_i),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (wbs_dat_i),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (cmd_data_o)
  );

  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dat;
  assign cmd_valid_o = ~w_empty;
  assign irq_o       = r_irq;

endmodule

// File: tb/tb_gpu_cmd_fifo.sv
// Scenario bench for gpu_cmd_fifo: bus tasks drive Wishbone accesses, a
// queue holds the command words expected on the stream, in order.
module tb_gpu_cmd_fifo;

  localparam int DEPTH     = 16;
  localparam int LOW_WATER = 4;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = '0;
  logic [31:0] wbs_dat_i = '0;
  logic [3:0]  wbs_adr_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        cmd_valid_o;
  logic [31:0] cmd_data_o;
  logic        cmd_ready_i = 1'b0;
  logic        irq_o;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] sb[$];
  logic        flush_cycle = 1'b0;
  logic [31:0] mon_exp;

  gpu_cmd_fifo #(.DEPTH(DEPTH), .LOW_WATER(LOW_WATER)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .cmd_valid_o (cmd_valid_o),
    .cmd_data_o  (cmd_data_o),
    .cmd_ready_i (cmd_ready_i),
    .irq_o       (irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Stream scoreboard: a handshake visible mid-cycle pops on the next edge.
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i && cmd_valid_o === 1'b1 && cmd_ready_i && !flush_cycle) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL stream_extra: got word %h, none expected", cmd_data_o);
      end else begin
        mon_exp = sb.pop_front();
        if (cmd_data_o !== mon_exp) begin
          n_errors++;
          $display("FAIL stream_order: got %h want %h", cmd_data_o, mon_exp);
        end
      end
    end
  end

  function automatic logic [31:0] exp_status(input int cnt, input bit ovf, input bit ien);
    logic [31:0] s;
    s        = '0;
    s[7:0]   = cnt[7:0];
    s[8]     = (cnt == 0);
    s[9]     = (cnt == DEPTH);
    s[10]    = ovf;
    s[11]    = (cnt <= LOW_WATER);
    s[12]    = ien;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic bus_xfer(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic rdy, input logic rdy_post,
                          input bit push_ok, input string tag, output logic [31:0] rdata);
    @(posedge wb_clk_i); #1;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    cmd_ready_i = rdy;
    flush_cycle = we && (adr == 4'd2) && sel[0] && dat[0];
    @(posedge wb_clk_i); #1;
    cmd_ready_i = rdy_post;
    if (flush_cycle) sb.delete();
    flush_cycle = 1'b0;
    if (push_ok) sb.push_back(dat);
    n_checks++;
    if (wbs_ack_o !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_ack: got %b want 1", tag, wbs_ack_o);
    end
    rdata = wbs_dat_o;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    @(posedge wb_clk_i); #1;
    n_checks++;
    if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
      n_errors++;
      $display("FAIL %s_ack_drop: got ack=%b dat=%h want ack=0 dat=0", tag, wbs_ack_o, wbs_dat_o);
    end
  endtask

  task automatic wb_write(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                          input bit push_ok, input string tag);
    logic [31:0] rd;
    bus_xfer(1'b1, adr, dat, sel, cmd_ready_i, cmd_ready_i, push_ok, tag, rd);
    chk({tag, "_wdat"}, rd, 32'h0);
  endtask

  task automatic wb_read(input logic [3:0] adr, input string tag, output logic [31:0] rd);
    bus_xfer(1'b0, adr, 32'h0, 4'hF, cmd_ready_i, cmd_ready_i, 1'b0, tag, rd);
  endtask

  task automatic drain(input int exp_cycles, input string tag);
    int n;
    n = 0;
    @(posedge wb_clk_i); #1;
    cmd_ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge wb_clk_i); #1;
      n++;
      if (cmd_valid_o !== 1'b1) break;
    end
    cmd_ready_i = 1'b0;
    chk({tag, "_valid_low"}, {31'b0, cmd_valid_o}, 32'h0);
    chk({tag, "_sb_left"}, sb.size(), 32'h0);
    if (exp_cycles >= 0) chk({tag, "_cycles"}, n, exp_cycles);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    wb_rst_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    chk("rst_ack", {31'b0, wbs_ack_o}, 32'h0);
    chk("rst_dat", wbs_dat_o, 32'h0);
    chk("rst_valid", {31'b0, cmd_valid_o}, 32'h0);
    chk("rst_irq", {31'b0, irq_o}, 32'h0);
    wb_read(4'd1, "rst_status", rd);
    chk("rst_status", rd, exp_status(0, 1'b0, 1'b0));
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    cmd_ready_i = 1'b0;
    for (int i = 1; i <= 3; i++) wb_write(4'd0, 32'hA5A5_0000 + i, 4'h0, 1'b1, "basic_push");
    wb_read(4'd1, "basic_status", rd);
    chk("basic_status", rd, exp_status(3, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(posedge wb_clk_i); #1;
      chk("basic_hold_valid", {31'b0, cmd_valid_o}, 32'h1);
      chk("basic_hold_data", cmd_data_o, 32'hA5A5_0001);
    end
    drain(3, "basic_drain");
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    cmd_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) wb_write(4'd0, 32'h0000_0100 + i, 4'hF, 1'b1, "ovf_push");
    wb_write(4'd0, 32'h0000_01EE, 4'hF, 1'b0, "ovf_push17");
    wb_read(4'd1, "ovf_status", rd);
    chk("ovf_status", rd, exp_status(DEPTH, 1'b1, 1'b0));
    wb_write(4'd2, 32'h3, 4'hE, 1'b0, "ovf_ctrl_nosel");
    wb_read(4'd1, "ovf_status_nosel", rd);
    chk("ovf_status_nosel", rd, exp_status(DEPTH, 1'b1, 1'b0));
    wb_write(4'd2, 32'h2, 4'h1, 1'b0, "ovf_clear");
    wb_read(4'd1, "ovf_status_clr", rd);
    chk("ovf_status_clr", rd, exp_status(DEPTH, 1'b0, 1'b0));
  endtask

  task automatic test_full_pop();
    logic [31:0] rd;
    // FIFO is full here; ready rises together with the push request.
    bus_xfer(1'b1, 4'd0, 32'h0000_0110, 4'hF, 1'b1, 1'b0, 1'b1, "fullpop_push", rd);
    chk("fullpop_wdat", rd, 32'h0);
    wb_read(4'd1, "fullpop_status", rd);
    chk("fullpop_status", rd, exp_status(DEPTH, 1'b0, 1'b0));
    drain(DEPTH, "fullpop_drain");
  endtask

  task automatic test_flush();
    logic [31:0] rd;
    cmd_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) wb_write(4'd0, 32'h0000_0200 + i, 4'hF, 1'b1, "flush_push");
    bus_xfer(1'b1, 4'd2, 32'h1, 4'h1, 1'b1, 1'b1, 1'b0, "flush_ctrl", rd);
    chk("flush_valid", {31'b0, cmd_valid_o}, 32'h0);
    cmd_ready_i = 1'b0;
    wb_read(4'd1, "flush_status", rd);
    chk("flush_status", rd, exp_status(0, 1'b0, 1'b0));
    wb_write(4'd0, 32'h0000_0300, 4'hF, 1'b1, "flush_repush");
    drain(1, "flush_drain");
  endtask

  task automatic test_irq();
    logic [31:0] rd;
    cmd_ready_i = 1'b0;
    wb_write(4'd2, 32'h4, 4'h1, 1'b0, "irq_en");
    chk("irq_empty_high", {31'b0, irq_o}, 32'h1);
    for (int i = 0; i < 4; i++) wb_write(4'd0, 32'h0000_0400 + i, 4'hF, 1'b1, "irq_push");
    chk("irq_at4", {31'b0, irq_o}, 32'h1);
    wb_write(4'd0, 32'h0000_0404, 4'hF, 1'b1, "irq_push5");
    chk("irq_at5", {31'b0, irq_o}, 32'h0);
    wb_read(4'd1, "irq_status5", rd);
    chk("irq_status5", rd, exp_status(5, 1'b0, 1'b1));
    @(posedge wb_clk_i); #1;
    cmd_ready_i = 1'b1;
    @(posedge wb_clk_i); #1;
    cmd_ready_i = 1'b0;
    chk("irq_lag", {31'b0, irq_o}, 32'h0);
    @(posedge wb_clk_i); #1;
    chk("irq_rise", {31'b0, irq_o}, 32'h1);
    wb_read(4'd9, "irq_rd9", rd);
    chk("irq_rd9", rd, 32'h0);
    wb_write(4'd9, 32'hFFFF_FFFF, 4'hF, 1'b0, "irq_wr9");
    wb_write(4'd1, 32'hFFFF_FFFF, 4'hF, 1'b0, "irq_wr_status");
    wb_read(4'd1, "irq_status4", rd);
    chk("irq_status4", rd, exp_status(4, 1'b0, 1'b1));
    wb_read(4'd2, "irq_ctrl_rd", rd);
    chk("irq_ctrl_rd", rd, 32'h4);
    drain(4, "irq_drain");
    wb_write(4'd2, 32'h0, 4'h1, 1'b0, "irq_dis");
    chk("irq_off", {31'b0, irq_o}, 32'h0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    cmd_ready_i = 1'b0;
    wb_write(4'd2, 32'h4, 4'h1, 1'b0, "midrst_en");
    for (int i = 0; i < 2; i++) wb_write(4'd0, 32'h0000_0500 + i, 4'hF, 1'b1, "midrst_push");
    @(posedge wb_clk_i); #1;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 4'd0; wbs_dat_i = 32'h0000_05FF; wbs_sel_i = 4'hF;
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wb_rst_i = 1'b0;
    sb.delete();
    chk("midrst_ack", {31'b0, wbs_ack_o}, 32'h0);
    chk("midrst_valid", {31'b0, cmd_valid_o}, 32'h0);
    chk("midrst_irq", {31'b0, irq_o}, 32'h0);
    wb_read(4'd1, "midrst_status", rd);
    chk("midrst_status", rd, exp_status(0, 1'b0, 1'b0));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop();
    test_flush();
    test_irq();
    test_reset_mid();
    repeat (2) @(posedge wb_clk_i);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
